// File: rtl/pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : pc_sequencer                                         |
// | Description : Program counter owner for the single-cycle core.     |
// |               Selects sequential / branch / JAL / JALR next PC,    |
// |               redirects misaligned targets to a trap vector and    |
// |               keeps branch statistics counters.                    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        is_branch,
   input  logic        is_jal,
   input  logic        is_jalr,
   input  logic        br_taken,
   input  logic [31:0] imm,
   input  logic [31:0] rs1_val,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        instr_valid,
   output logic        trap,
   output logic [31:0] trap_pc,
   output logic [31:0] branch_count,
   output logic [31:0] taken_count
);

   // BOOT and TRAP are both single-cycle bubbles in front of RUN.
   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_TRAP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] trap_pc_q, trap_pc_d;
   logic [31:0] branch_count_q, branch_count_d;
   logic [31:0] taken_count_q, taken_count_d;
   logic        instr_valid_q, instr_valid_d;
   logic        trap_q, trap_d;

   logic [31:0] seq_pc;
   logic [31:0] rel_target;
   logic [31:0] jalr_target;
   logic [31:0] target;
   logic        redirect;
   logic        misaligned;
   logic        active;

   // Candidate targets and the priority-selected next PC while running.
   always_comb begin
      seq_pc      = pc_q + 32'd4;
      rel_target  = pc_q + imm;
      jalr_target = (rs1_val + imm) & ~32'h1;
      redirect    = is_jalr || is_jal || (is_branch && br_taken);
      if (is_jalr) begin
         target = jalr_target;
      end else if (is_jal || (is_branch && br_taken)) begin
         target = rel_target;
      end else begin
         target = seq_pc;
      end
      misaligned = redirect && (target[1:0] != 2'b00);
      active     = (state_q == ST_RUN) && !stall;
   end

   // Next-state, next-PC, trap capture and statistics counters.
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      trap_pc_d      = trap_pc_q;
      branch_count_d = branch_count_q;
      taken_count_d  = taken_count_q;

      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_TRAP: state_d = ST_RUN;
         ST_RUN: begin
            if (active) begin
               if (misaligned) begin
                  // The faulting target is never architecturally visible.
                  pc_d      = TRAP_VECTOR;
                  trap_pc_d = pc_q;
                  state_d   = ST_TRAP;
               end else begin
                  pc_d = target;
               end
            end
         end
         default: state_d = ST_BOOT;
      endcase

      // A trapping branch still counts as executed.
      if (active && is_branch) begin
         branch_count_d = branch_count_q + 32'd1;
         if (br_taken) begin
            taken_count_d = taken_count_q + 32'd1;
         end
      end

      // Status flags are registered from the state being entered.
      instr_valid_d = (state_d == ST_RUN);
      trap_d        = (state_d == ST_TRAP);
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_BOOT;
         pc_q           <= RESET_VECTOR;
         trap_pc_q      <= 32'h0;
         branch_count_q <= 32'h0;
         taken_count_q  <= 32'h0;
         instr_valid_q  <= 1'b0;
         trap_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         trap_pc_q      <= trap_pc_d;
         branch_count_q <= branch_count_d;
         taken_count_q  <= taken_count_d;
         instr_valid_q  <= instr_valid_d;
         trap_q         <= trap_d;
      end
   end

   assign pc           = pc_q;
   assign pc_plus4     = seq_pc;
   assign instr_valid  = instr_valid_q;
   assign trap         = trap_q;
   assign trap_pc      = trap_pc_q;
   assign branch_count = branch_count_q;
   assign taken_count  = taken_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_pc_sequencer                                      |
// | Description : Self-checking bench for pc_sequencer with a          |
// |               behavioural reference model and random traffic.      |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_pc_sequencer;

   localparam logic [31:0] RV = 32'h0000_0000;
   localparam logic [31:0] TV = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        is_branch = 1'b0;
   logic        is_jal = 1'b0;
   logic        is_jalr = 1'b0;
   logic        br_taken = 1'b0;
   logic [31:0] imm = 32'h0;
   logic [31:0] rs1_val = 32'h0;
   logic [31:0] pc, pc_plus4, trap_pc, branch_count, taken_count;
   logic        instr_valid, trap;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: phase 0 = boot bubble, 1 = running, 2 = trap bubble.
   logic [31:0] m_pc, m_trap_pc, m_bc, m_tc;
   int          m_phase;

   pc_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
      .clk(clk), .reset(reset), .stall(stall), .is_branch(is_branch),
      .is_jal(is_jal), .is_jalr(is_jalr), .br_taken(br_taken), .imm(imm),
      .rs1_val(rs1_val), .pc(pc), .pc_plus4(pc_plus4),
      .instr_valid(instr_valid), .trap(trap), .trap_pc(trap_pc),
      .branch_count(branch_count), .taken_count(taken_count)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_pc = RV; m_trap_pc = 32'h0; m_bc = 32'h0; m_tc = 32'h0; m_phase = 0;
   endtask

   // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge.
   task automatic drive(input logic s, input logic b, input logic j, input logic jr,
                        input logic t, input logic [31:0] im, input logic [31:0] r);
      logic [31:0] tgt;
      logic        redir;
      stall = s; is_branch = b; is_jal = j; is_jalr = jr; br_taken = t;
      imm = im; rs1_val = r;
      if (m_phase != 1) begin
         m_phase = 1;
      end else if (!s) begin
         redir = jr || j || (b && t);
         if (jr)        tgt = (r + im) & 32'hFFFF_FFFE;
         else if (redir) tgt = m_pc + im;
         else           tgt = m_pc + 32'd4;
         if (b)       m_bc = m_bc + 32'd1;
         if (b && t)  m_tc = m_tc + 32'd1;
         if (redir && (tgt % 4 != 0)) begin
            m_trap_pc = m_pc; m_pc = TV; m_phase = 2;
         end else begin
            m_pc = tgt;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   // Reach an aligned address with a JAL from the current PC.
   task automatic goto(input logic [31:0] addr);
      while (m_phase != 1) idle();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, addr - m_pc, 32'h0);
   endtask

   task automatic test_reset();
      reset = 1'b1; model_reset();
      #1;
      n_checks++; if (pc !== m_pc) begin n_errors++; $display("FAIL reset_pc got %h exp %h", pc, m_pc); end
      n_checks++; if (instr_valid !== 1'b0 || trap !== 1'b0) begin n_errors++; $display("FAIL reset_flags got iv=%b trap=%b exp 0 0", instr_valid, trap); end
      n_checks++; if (trap_pc !== 32'h0 || branch_count !== 32'h0 || taken_count !== 32'h0) begin n_errors++; $display("FAIL reset_regs got %h %h %h exp 0", trap_pc, branch_count, taken_count); end
      @(posedge clk); #1;
      reset = 1'b0;
      idle();
      n_checks++; if (pc !== m_pc || instr_valid !== 1'b1) begin n_errors++; $display("FAIL boot_bubble got pc=%h iv=%b exp pc=%h iv=1", pc, instr_valid, m_pc); end
      for (int i = 0; i < 3; i++) begin
         idle();
         n_checks++; if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4) begin n_errors++; $display("FAIL seq_pc got %h/%h exp %h", pc, pc_plus4, m_pc); end
      end
   endtask

   task automatic test_branches();
      goto(32'h10);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h20, 32'h0);
      n_checks++; if (pc !== m_pc || branch_count !== m_bc || taken_count !== m_tc) begin n_errors++; $display("FAIL br_taken got pc=%h bc=%h tc=%h exp pc=%h bc=%h tc=%h", pc, branch_count, taken_count, m_pc, m_bc, m_tc); end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0);
      n_checks++; if (pc !== m_pc || branch_count !== m_bc || taken_count !== m_tc) begin n_errors++; $display("FAIL br_not_taken got pc=%h bc=%h tc=%h exp pc=%h bc=%h tc=%h", pc, branch_count, taken_count, m_pc, m_bc, m_tc); end
   endtask

   task automatic test_jalr();
      goto(32'h40);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4, 32'h1001);
      n_checks++; if (pc !== m_pc || trap !== 1'b0) begin n_errors++; $display("FAIL jalr_align got pc=%h trap=%b exp pc=%h trap=0", pc, trap, m_pc); end
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h1002);
      n_checks++; if (pc !== m_pc || trap !== 1'b1 || trap_pc !== m_trap_pc) begin n_errors++; $display("FAIL jalr_trap got pc=%h trap=%b tpc=%h exp pc=%h trap=1 tpc=%h", pc, trap, trap_pc, m_pc, m_trap_pc); end
      idle();
   endtask

   task automatic test_misaligned_jal();
      goto(32'h50);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h6, 32'h0);
      n_checks++; if (pc !== m_pc || trap_pc !== m_trap_pc || trap !== 1'b1 || instr_valid !== 1'b0) begin n_errors++; $display("FAIL jal_trap got pc=%h tpc=%h trap=%b iv=%b exp pc=%h tpc=%h trap=1 iv=0", pc, trap_pc, trap, instr_valid, m_pc, m_trap_pc); end
      idle();
      n_checks++; if (pc !== m_pc || trap !== 1'b0 || instr_valid !== 1'b1) begin n_errors++; $display("FAIL trap_bubble got pc=%h trap=%b iv=%b exp pc=%h trap=0 iv=1", pc, trap, instr_valid, m_pc); end
      idle();
      n_checks++; if (pc !== m_pc) begin n_errors++; $display("FAIL after_trap got %h exp %h", pc, m_pc); end
   endtask

   task automatic test_stall();
      goto(32'h20);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0);
         n_checks++; if (pc !== m_pc || branch_count !== m_bc || taken_count !== m_tc) begin n_errors++; $display("FAIL stall_hold got pc=%h bc=%h tc=%h exp pc=%h bc=%h tc=%h", pc, branch_count, taken_count, m_pc, m_bc, m_tc); end
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0);
      n_checks++; if (pc !== m_pc || branch_count !== m_bc || taken_count !== m_tc) begin n_errors++; $display("FAIL stall_release got pc=%h bc=%h tc=%h exp pc=%h bc=%h tc=%h", pc, branch_count, taken_count, m_pc, m_bc, m_tc); end
   endtask

   task automatic test_wrap();
      while (m_phase != 1) idle();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC);
      idle();
      n_checks++; if (pc !== m_pc || pc !== 32'h0) begin n_errors++; $display("FAIL pc_wrap got %h exp %h", pc, m_pc); end
      force dut.taken_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.taken_count_q;
      m_tc = 32'hFFFF_FFFF;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0);
      n_checks++; if (taken_count !== m_tc || branch_count !== m_bc) begin n_errors++; $display("FAIL cnt_wrap got tc=%h bc=%h exp tc=%h bc=%h", taken_count, branch_count, m_tc, m_bc); end
   endtask

   task automatic test_random();
      logic [31:0] im;
      int          sel;
      for (int i = 0; i < 400; i++) begin
         sel = int'($urandom_range(0, 4));
         im  = $urandom;
         if ($urandom_range(0, 7) != 0) im[1:0] = 2'b00;
         drive(($urandom_range(0, 3) == 0), (sel == 1 || sel == 2), (sel == 3), (sel == 4),
               (sel == 2) || (sel == 0 && $urandom_range(0, 1) == 1), im, $urandom);
         n_checks++;
         if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 || instr_valid !== (m_phase == 1) ||
             trap !== (m_phase == 2) || trap_pc !== m_trap_pc || branch_count !== m_bc ||
             taken_count !== m_tc) begin
            n_errors++;
            $display("FAIL rand_%0d got pc=%h iv=%b trap=%b tpc=%h bc=%h tc=%h exp pc=%h phase=%0d tpc=%h bc=%h tc=%h",
                     i, pc, instr_valid, trap, trap_pc, branch_count, taken_count,
                     m_pc, m_phase, m_trap_pc, m_bc, m_tc);
         end
      end
   endtask

   task automatic test_reset_in_trap();
      goto(32'h80);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2, 32'h0);
      n_checks++; if (trap !== 1'b1) begin n_errors++; $display("FAIL pre_reset_trap got %b exp 1", trap); end
      reset = 1'b1; model_reset();
      #1;
      n_checks++; if (pc !== m_pc || trap !== 1'b0 || instr_valid !== 1'b0 || branch_count !== m_bc) begin n_errors++; $display("FAIL reset_in_trap got pc=%h trap=%b iv=%b bc=%h exp pc=%h 0 0 %h", pc, trap, instr_valid, branch_count, m_pc, m_bc); end
      @(posedge clk); #1;
      reset = 1'b0;
      idle();
      idle();
      n_checks++; if (pc !== m_pc || instr_valid !== 1'b1) begin n_errors++; $display("FAIL post_reset got pc=%h iv=%b exp pc=%h iv=1", pc, instr_valid, m_pc); end
   endtask

   initial begin
      test_reset();
      test_branches();
      test_jalr();
      test_misaligned_jal();
      test_stall();
      test_wrap();
      test_random();
      test_reset_in_trap();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter of the single-cycle core and sequences instruction flow.
- Each cycle it picks the next PC from four sources: sequential, conditional branch (using the branch unit's taken flag), JAL, or JALR.
- Detects misaligned control-flow targets and redirects to a trap vector through a small FSM.
- Keeps 32-bit branch statistics counters for debug and performance monitoring.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on a misaligned-target trap.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  freeze the PC, FSM and counters this cycle.
- is_branch  in  1  current instruction is a conditional branch.
- is_jal  in  1  current instruction is JAL.
- is_jalr  in  1  current instruction is JALR.
- br_taken  in  1  taken flag from the branch comparator; only meaningful when is_branch=1.
- imm  in  32  sign-extended immediate (B or J offset, or I offset for JALR).
- rs1_val  in  32  rs1 operand, used only by JALR.
- pc  out  32  current PC, registered.
- pc_plus4  out  32  pc+4, combinational; serves as the link value.
- instr_valid  out  1  the current pc fetch is architecturally valid.
- trap  out  1  one-cycle pulse on the cycle a trap is taken.
- trap_pc  out  32  PC of the faulting instruction; holds until the next trap.
- branch_count  out  32  number of branches executed.
- taken_count  out  32  number of branches taken.

Behaviour:
- Reset (asynchronous, active-high), all values take effect immediately:
  - pc=RESET_VECTOR, state=BOOT, instr_valid=0, trap=0.
  - trap_pc=0, branch_count=0, taken_count=0.
- FSM states are BOOT, RUN and TRAP.
- BOOT:
  - instr_valid=0.
  - Next edge: state goes to RUN and pc holds RESET_VECTOR. This one-cycle bubble covers instruction-memory read latency.
  - stall is ignored in BOOT.
- RUN:
  - instr_valid=1.
  - If stall=1: pc, state and counters hold. No trap detection is done.
  - Otherwise the target is selected by priority (exactly one control input is expected):
    - is_jalr: target = (rs1_val + imm) & ~32'h1.
    - else is_jal: target = pc + imm.
    - else is_branch && br_taken: target = pc + imm.
    - else: target = pc + 4.
  - All additions are modulo 2^32; wrap-around is silent. For example, pc=FFFF_FFFC sequential gives 0000_0000.
  - Misaligned target: target[1:0] != 0 on a redirect (jalr, jal or taken branch). On the next edge:
    - pc=TRAP_VECTOR, trap_pc=pc, state=TRAP.
    - pc never takes the misaligned value.
  - Aligned target: pc=target on the next edge.
- Counters (RUN, stall=0 only):
  - is_branch increments branch_count.
  - is_branch && br_taken increments taken_count.
  - A branch that traps is still counted.
  - Both counters wrap from FFFF_FFFF to 0.
- TRAP:
  - trap=1 and instr_valid=0 for exactly this one cycle.
  - Next edge: state=RUN and pc holds TRAP_VECTOR. This state is the flush bubble.
  - stall is ignored in TRAP.
- A control input outside RUN, or while stalled, has no effect.
- Reset asserted mid-operation (any state, including TRAP) overrides everything immediately.
- All outputs except pc_plus4 are registered.

Test Plan:
- Reset release: reset held then dropped at RESET_VECTOR=0.
  - Required: pc=0 with instr_valid=0 for 1 cycle, then RUN.
  - Sequential flow then gives pc=0,4,8,C.
- Taken and not-taken branches at pc=0x10 with imm=0x20:
  - br_taken=1: next pc=0x30, branch_count=1, taken_count=1.
  - Repeat at 0x30 with br_taken=0: next pc=0x34, branch_count=2, taken_count=1.
- JALR alignment at pc=0x40, rs1_val=0x1001, imm=0x4:
  - Target is 0x1004 (bit0 cleared), no trap.
  - Repeat with rs1_val=0x1002, imm=0: trap.
- Misaligned JAL at pc=0x50, imm=0x6:
  - Next edge: pc=0x100, trap_pc=0x50, trap=1 for 1 cycle, instr_valid=0.
  - Then RUN at 0x100 and pc goes to 0x104.
- Stall with is_branch=1, br_taken=1 and stall=1 for 3 cycles at pc=0x20:
  - pc stays 0x20 and counters are unchanged.
  - First cycle with stall=0: pc=0x20+imm, counters increment once.
- Wrap-around and mid-op reset:
  - pc=FFFF_FFFC sequential gives 0; a branch with taken_count preset to FFFF_FFFF (via a forced run) gives 0.
  - Reset asserted during TRAP immediately gives pc=RESET_VECTOR, trap=0, state=BOOT.
